// File: rtl/line_burst_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_burst_adapter_pkg
//  Purpose  : Shared types and default widths for the line burst adapter,
//             its cache-side requester and memory-side models.
//  Revision : 1.0  initial release
// ============================================================================
package line_burst_adapter_pkg;

  // Burst sequencing states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_t;

  // Default geometry: a 256-bit cache line over a 64-bit memory bus.
  localparam int LINE_W_DEFAULT = 256;
  localparam int BUS_W_DEFAULT  = 64;

endpackage : line_burst_adapter_pkg
`default_nettype wire

// File: rtl/line_burst_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : line_burst_adapter
//  Purpose  : Turns a whole-line cache read/write into an ascending burst of
//             BUS_W-wide beats and reassembles read beats into a full line.
//  Revision : 1.0  initial release
// ============================================================================
module line_burst_adapter
  import line_burst_adapter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int BUS_W  = BUS_W_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // Cache side
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic [LINE_W-1:0] line_rdata,
  output logic              line_resp,
  // Memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_resp
);

  // Geometry derived from the widths; not meant to be overridden.
  localparam int BEATS = LINE_W / BUS_W;
  localparam int OFF_W = $clog2(LINE_W / 8);
  // A single-beat line still gets a 1-bit counter that simply stays at 0.
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  burst_state_t      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wbuf;
  logic [LINE_W-1:0] r_rbuf;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_line_resp;
  logic              w_last;

  assign w_last = (r_cnt == LAST_BEAT);

  // Burst sequencer: accepts a line request, walks the beats on each
  // mem_resp and emits a one-cycle completion pulse. The counter is held
  // (not incremented) on the final beat so it never wraps inside a burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wbuf      <= '0;
      r_rbuf      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_line_resp <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (line_write || line_read) begin
            r_addr <= {line_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            r_cnt  <= '0;
            // Write takes priority when both requests are present.
            if (line_write) begin
              r_wbuf      <= line_wdata;
              r_mem_write <= 1'b1;
              r_state     <= WR_BURST;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= RD_BURST;
            end
          end
        end

        RD_BURST: begin
          if (mem_resp) begin
            r_rbuf[int'(r_cnt)*BUS_W +: BUS_W] <= mem_rdata;
            if (w_last) begin
              r_mem_read  <= 1'b0;
              r_line_resp <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        WR_BURST: begin
          if (mem_resp) begin
            if (w_last) begin
              r_mem_write <= 1'b0;
              r_line_resp <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end

        DONE: begin
          r_line_resp <= 1'b0;
          r_state     <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers; the write beat is a register-only
  // select, forced to zero outside a write burst so reset shows all zeros.
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;
  assign mem_addr   = r_addr;
  assign line_resp  = r_line_resp;
  assign line_rdata = r_rbuf;
  assign mem_wdata  = (r_state == WR_BURST) ? r_wbuf[int'(r_cnt)*BUS_W +: BUS_W]
                                            : '0;

endmodule : line_burst_adapter
`default_nettype wire

// File: tb/tb_line_burst_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_burst_adapter
//  Purpose  : Self-checking bench for line_burst_adapter: a 4-beat instance
//             (256/64) and a single-beat instance (256/256).
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_burst_adapter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 4-beat instance signals
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, mem_read, mem_write, mem_resp;
  logic [31:0]  mem_addr;
  logic [63:0]  mem_wdata, mem_rdata;

  // single-beat instance signals
  logic         b_line_read, b_line_write;
  logic [31:0]  b_line_addr;
  logic [255:0] b_line_wdata, b_line_rdata;
  logic         b_line_resp, b_mem_read, b_mem_write, b_mem_resp;
  logic [31:0]  b_mem_addr;
  logic [255:0] b_mem_wdata, b_mem_rdata;

  int checks = 0;
  int errors = 0;

  // Reference state: what line_rdata of each instance should show.
  logic [255:0] model_rdata;
  logic [255:0] b_model_rdata;

  line_burst_adapter #(.LINE_W(256), .BUS_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .line_read(line_read), .line_write(line_write), .line_addr(line_addr),
    .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  line_burst_adapter #(.LINE_W(256), .BUS_W(256), .ADDR_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .line_read(b_line_read), .line_write(b_line_write), .line_addr(b_line_addr),
    .line_wdata(b_line_wdata), .line_rdata(b_line_rdata), .line_resp(b_line_resp),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_resp(b_mem_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // One complete line transaction on the 4-beat instance, starting just
  // after a falling edge with the adapter idle. gN = stall cycles before
  // beat N; pat selects the fixed A0/B1/C2/D3 read beats.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [255:0] wd, input int g0, input int g1,
                     input int g2, input int g3, input bit pat);
    logic [255:0] exp_line;
    logic [63:0]  beat;
    int           gaps [4];
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    exp_line = '0;
    chk("idle_mem_read", mem_read, 1'b0);
    chk("idle_mem_write", mem_write, 1'b0);
    line_read = rd; line_write = wr; line_addr = addr; line_wdata = wd;
    @(negedge clk);
    // Data on the request port after accept must not matter.
    line_wdata = rand256();
    chk("burst_mem_read", mem_read, !wr);
    chk("burst_mem_write", mem_write, wr);
    chk("burst_addr", mem_addr, {addr[31:5], 5'b0});
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        if (wr) chk("stall_wdata", mem_wdata, wd[i*64 +: 64]);
        chk("stall_held", {mem_read, mem_write}, {!wr, wr});
        chk("stall_addr", mem_addr, {addr[31:5], 5'b0});
        @(negedge clk);
      end
      beat = pat ? {8{8'hA0 + 8'(8'h11 * i)}} : {$urandom, $urandom};
      mem_rdata = beat;
      mem_resp  = 1'b1;
      if (wr) chk("beat_wdata", mem_wdata, wd[i*64 +: 64]);
      chk("beat_held", {mem_read, mem_write}, {!wr, wr});
      exp_line[i*64 +: 64] = beat;
      @(negedge clk);
      mem_resp  = 1'b0;
      mem_rdata = {$urandom, $urandom};
      if (i < 3) chk("early_resp", line_resp, 1'b0);
    end
    chk("line_resp", line_resp, 1'b1);
    chk("end_mem_rw", {mem_read, mem_write}, 2'b00);
    line_read = 1'b0; line_write = 1'b0;
    if (!wr) model_rdata = exp_line;
    chk("line_rdata", line_rdata, model_rdata);
    @(negedge clk);
    chk("resp_pulse", line_resp, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    line_read = 0; line_write = 0; line_addr = 0; line_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    b_line_read = 0; b_line_write = 0; b_line_addr = 0; b_line_wdata = 0;
    b_mem_resp = 0; b_mem_rdata = 0;
    model_rdata = '0; b_model_rdata = '0;

    // Reset held with random activity on all inputs.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      line_read = 1'($urandom); line_write = 1'($urandom); line_addr = $urandom;
      line_wdata = rand256(); mem_resp = 1'($urandom); mem_rdata = {$urandom, $urandom};
      b_line_read = 1'($urandom); b_mem_resp = 1'($urandom);
      chk("rst_ctrl", {line_resp, mem_read, mem_write, b_line_resp, b_mem_read, b_mem_write}, '0);
      chk("rst_addr", {mem_addr, b_mem_addr}, '0);
      chk("rst_wdata", {mem_wdata, b_mem_wdata[191:0]}, '0);
      chk("rst_rdata", line_rdata | b_line_rdata, '0);
    end
    line_read = 0; line_write = 0; mem_resp = 0; b_line_read = 0; b_mem_resp = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_idle", {mem_read, mem_write, line_resp}, 3'b000);

    // Read with immediate beats and fixed pattern.
    txn(1, 0, 32'h0000_1234, '0, 0, 0, 0, 0, 1);
    chk("rd_pattern", line_rdata,
        {{8{8'hD3}}, {8{8'hC2}}, {8{8'hB1}}, {8{8'hA0}}});

    // Write with stalls 0/3/1/5; read line must stay put.
    txn(0, 1, 32'h0000_8F07,
        256'h3123456789ABCDEF_2123456789ABCDEF_1123456789ABCDEF_0123456789ABCDEF,
        0, 3, 1, 5, 0);

    // Both requests together: write wins.
    txn(1, 1, 32'h0004_0040, rand256(), 1, 0, 2, 0, 0);

    // Reset in the middle of a read, after two beats.
    line_read = 1'b1; line_addr = 32'h0000_5555;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom, $urandom};
      @(negedge clk);
      mem_resp = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {line_resp, mem_read, mem_write}, 3'b000);
    chk("midrst_addr", mem_addr, '0);
    chk("midrst_rdata", line_rdata, '0);
    model_rdata = '0;
    line_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {mem_read, mem_write}, 2'b00);
    txn(1, 0, 32'h0000_5555, '0, 0, 1, 0, 2, 0);

    // Single-beat instance: read then write.
    b_model_rdata = rand256();
    b_line_read = 1'b1; b_line_addr = 32'h0000_ABCD;
    @(negedge clk);
    chk("b_mem_read", b_mem_read, 1'b1);
    chk("b_addr", b_mem_addr, 32'h0000_ABC0);
    b_mem_rdata = b_model_rdata; b_mem_resp = 1'b1;
    @(negedge clk);
    b_mem_resp = 1'b0; b_mem_rdata = rand256();
    chk("b_rd_resp", b_line_resp, 1'b1);
    chk("b_rd_end", b_mem_read, 1'b0);
    chk("b_rdata", b_line_rdata, b_model_rdata);
    b_line_read = 1'b0;
    @(negedge clk);
    chk("b_resp_pulse", b_line_resp, 1'b0);
    b_line_wdata = rand256(); b_line_write = 1'b1; b_line_addr = 32'h1234_5678;
    @(negedge clk);
    chk("b_wdata", b_mem_wdata, b_line_wdata);
    chk("b_mem_write", b_mem_write, 1'b1);
    b_mem_resp = 1'b1;
    @(negedge clk);
    b_mem_resp = 1'b0;
    chk("b_wr_resp", b_line_resp, 1'b1);
    chk("b_rdata_kept", b_line_rdata, b_model_rdata);
    b_line_write = 1'b0;
    @(negedge clk);

    // Randomised transactions on the 4-beat instance.
    for (int n = 0; n < 20; n++) begin
      bit r, w;
      r = 1'($urandom);
      w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      txn(r, w, $urandom, rand256(), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3), 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_line_burst_adapter
`default_nettype wire

// File: doc/line_burst_adapter.md
# line_burst_adapter

Converts a cache's whole-line read/write request into a multi-beat burst on a narrower memory bus, and reassembles read beats into a full line. It sits between the last-level cache's memory port and physical memory. It is the sequential, parametrised successor to the line/word width adapter: line width, bus width and beat count are all parameters.

## Interface
- `LINE_W`, default 256: cache line width in bits; integer multiple of `BUS_W`.
- `BUS_W`, default 64: memory data bus width in bits; power of two, at least 32.
- `ADDR_W`, default 32: address width.
- Derived constant (not overridable): `BEATS = LINE_W/BUS_W`, a power of two ≥ 1.
- Derived constant (not overridable): `OFF_W = $clog2(LINE_W/8)`.

Ports:
- `clk` in 1: the single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `line_read` in 1: line read request; level, held until `line_resp`.
- `line_write` in 1: line write request; level, held until `line_resp`.
- `line_addr` in `ADDR_W`: request address; any byte offset.
- `line_wdata` in `LINE_W`: write line; sampled only at accept.
- `line_rdata` out `LINE_W`: assembled read line.
- `line_resp` out 1: one-cycle completion pulse.
- `mem_read` out 1: burst read; held for the whole burst.
- `mem_write` out 1: burst write; held for the whole burst.
- `mem_addr` out `ADDR_W`: line-aligned address, constant during the burst.
- `mem_wdata` out `BUS_W`: current write beat.
- `mem_rdata` in `BUS_W`: read beat, valid when `mem_resp` is high.
- `mem_resp` in 1: per-beat acknowledge.

## Operation
States are `IDLE`, `RD_BURST`, `WR_BURST` and `DONE`.

- **IDLE**
  - Request present: latch `line_addr` with the low `OFF_W` bits cleared, clear the beat counter, and go to the burst state.
  - `line_write` wins over `line_read` if both are high.
  - On a write, also latch `line_wdata` into the write buffer.
  - `mem_resp` arriving in `IDLE` or `DONE` is ignored.
- **RD_BURST**
  - `mem_read` = 1.
  - On each `mem_resp`: store `mem_rdata` into read buffer slice `[cnt*BUS_W +: BUS_W]` and increment `cnt`.
  - On the beat with `cnt == BEATS-1`, go to `DONE`.
- **WR_BURST**
  - `mem_write` = 1 and `mem_wdata` = write buffer slice `[cnt*BUS_W +: BUS_W]`.
  - On each `mem_resp`, increment `cnt`.
  - On the last beat, go to `DONE`.
- **DONE**
  - `line_resp` = 1 for exactly one cycle, then go to `IDLE`.
- **Beat order and counter**
  - Beats run in ascending order: beat 0 is the least-significant slice.
  - The counter is `$clog2(BEATS)` bits; for `BEATS == 1` a 1-bit counter is used and the first `mem_resp` is also the last.
  - The counter never wraps inside a burst.
- **`line_rdata`**
  - Driven directly from the read buffer.
  - Holds its value after `line_resp` until the next read burst overwrites it beat by beat.
  - Write bursts do not disturb it.
- **Requester contract:** the requester deasserts its request in the cycle after `line_resp`. The adapter accepts a new request no earlier than the cycle after `DONE`.
- **Reset** (asynchronous, any state, including mid-burst):
  - State returns to `IDLE` and the counter to 0.
  - `mem_read`, `mem_write` and `line_resp` go to 0.
  - `mem_addr`, `mem_wdata`, `line_rdata` and both buffers go to 0.
  - A partial burst is abandoned, not resumed.

## Timing
- Accept at cycle t (`IDLE` with a request). `mem_read`/`mem_write` are asserted from t+1.
- Last `mem_resp` at cycle u, then `line_resp` at u+1 and `IDLE` at u+2.
- Minimum latency from request to `line_resp` is `BEATS+1` cycles.
- `mem_resp` may have arbitrary gap cycles between beats; outputs are held stable across gaps.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_resp` or `line_*` inputs to any output.

## Structure
- Package `line_burst_adapter_pkg` holds the state enum `burst_state_t` and the default `LINE_W`/`BUS_W` constants, shared with cache and memory models.
- No sub-module; a single module of roughly 150–250 lines.

## Test plan
Unless stated otherwise, `LINE_W`=256 and `BUS_W`=64.

1. **Reset:** hold `rst_n`=0 with random inputs -> all outputs 0; release -> `IDLE`, no `mem_*` activity.
2. **Read:** `line_read` at 0x0000_1234 with immediate `mem_resp` and beats 0xA0…A0, 0xB1…B1, 0xC2…C2, 0xD3…D3 -> `mem_addr`=0x0000_1220, 4 cycles of `mem_read`, `line_resp` one cycle after the 4th beat, `line_rdata`={D3…,C2…,B1…,A0…}.
3. **Write with stalls:** `line_write` with `line_wdata`=0x0123…CDEF pattern, `mem_resp` gaps of 0/3/1/5 cycles -> each beat stays stable until acked, slices ordered 0→3, `line_wdata` changes after accept have no effect.
4. **Simultaneous request:** `line_read` and `line_write` together -> write burst only; `line_rdata` unchanged.
5. **Reset mid-burst:** `rst_n` pulsed low after beat 2 of a read -> outputs 0 at once; a following read completes correctly with 4 fresh beats.
6. **Single beat:** `BUS_W`=256 -> one `mem_resp` completes the burst and `line_resp` follows on the next cycle.
